// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// Pod reset sequencer: qualifies tag-done, staggers channel reset release,
// runs the cycle counter, watchdog and a one-entry print-stat buffer.
module bsg_manycore_pod_reset_sequencer #(
  parameter int num_channels_p   = 4,
  parameter int reset_depth_p    = 3,
  parameter int stagger_cycles_p = 2,
  parameter int ctr_width_p      = 32,
  parameter int timeout_cycles_p = 0,
  parameter int tag_width_p      = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  output logic [num_channels_p-1:0] channel_reset_o,
  output logic                      all_out_of_reset_o,
  input  logic                      finish_i,
  input  logic                      stat_v_i,
  input  logic [tag_width_p-1:0]    stat_tag_i,
  output logic                      stat_v_o,
  output logic [tag_width_p-1:0]    stat_tag_o,
  output logic [ctr_width_p-1:0]    stat_ctr_o,
  input  logic                      stat_yumi_i,
  output logic                      stat_drop_o,
  output logic [ctr_width_p-1:0]    ctr_o,
  output logic                      done_o,
  output logic                      timeout_o
);

  typedef enum logic [2:0] {
    WAIT_TAG, STAGGER, RUN, DONE, TIMEOUT
  } state_e;

  localparam int QW = $clog2(reset_depth_p + 1);
  localparam int IW =
    (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int GW =
    (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1;
  localparam int GL =
    (stagger_cycles_p > 0) ? stagger_cycles_p - 1 : 0;

  localparam logic [QW-1:0] QLAST = QW'(reset_depth_p - 1);
  localparam logic [IW-1:0] ILAST = IW'(num_channels_p - 1);
  localparam logic [GW-1:0] GLAST = GW'(GL);
  localparam logic [ctr_width_p-1:0] TLIM =
    ctr_width_p'(timeout_cycles_p);
  localparam bit TO_EN  = (timeout_cycles_p != 0);
  localparam bit ONE_GO =
    (stagger_cycles_p == 0) || (num_channels_p == 1);

  state_e                    state_q, state_d;
  logic [QW-1:0]             qual_q, qual_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [num_channels_p-1:0] rst_q, rst_d;
  logic [ctr_width_p-1:0]    ctr_q, ctr_d;
  logic                      sv_q, sv_d;
  logic [tag_width_p-1:0]    stag_q, stag_d;
  logic [ctr_width_p-1:0]    sctr_q, sctr_d;
  logic                      drop_q, drop_d;
  logic                      done_q, done_d;
  logic                      to_q, to_d;
  logic                      stat_act;

  // Next-state: sequencing FSM, counter, watchdog and stat buffer.
  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    ctr_d   = ctr_q;
    sv_d    = sv_q;
    stag_d  = stag_q;
    sctr_d  = sctr_q;
    drop_d  = drop_q;
    done_d  = done_q;
    to_d    = to_q;

    unique case (state_q)
      WAIT_TAG: begin
        if (&tag_done_i) begin
          if (qual_q == QLAST) begin
            qual_d = '0;
            if (ONE_GO) begin
              rst_d   = '0;
              state_d = RUN;
            end else begin
              rst_d[0] = 1'b0;
              idx_d    = IW'(1);
              gap_d    = '0;
              state_d  = STAGGER;
            end
          end else begin
            qual_d = qual_q + 1'b1;
          end
        end else begin
          qual_d = '0;
        end
      end
      STAGGER: begin
        if (gap_q == GLAST) begin
          rst_d[idx_q] = 1'b0;
          gap_d        = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == ILAST) state_d = RUN;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RUN: begin
        if (finish_i) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (TO_EN && ctr_q == TLIM) begin
          state_d = TIMEOUT;
          to_d    = 1'b1;
          rst_d   = '1;
        end else if (~&ctr_q) begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      DONE, TIMEOUT: begin
      end
      default: state_d = WAIT_TAG;
    endcase

    stat_act = (state_q == RUN) || (state_q == DONE);
    if (stat_act) begin
      if (stat_v_i && (!sv_q || stat_yumi_i)) begin
        sv_d   = 1'b1;
        stag_d = stat_tag_i;
        sctr_d = ctr_q;
      end else if (stat_v_i) begin
        drop_d = 1'b1;
      end else if (stat_yumi_i) begin
        sv_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= WAIT_TAG;
      qual_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      rst_q   <= '1;
      ctr_q   <= '0;
      sv_q    <= 1'b0;
      stag_q  <= '0;
      sctr_q  <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      ctr_q   <= ctr_d;
      sv_q    <= sv_d;
      stag_q  <= stag_d;
      sctr_q  <= sctr_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  // Consumer may only dequeue a valid entry.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && stat_yumi_i) assert (sv_q);
  end

  assign channel_reset_o    = rst_q;
  assign all_out_of_reset_o =
    (state_q == RUN) || (state_q == DONE);
  assign stat_v_o    = sv_q;
  assign stat_tag_o  = stag_q;
  assign stat_ctr_o  = sctr_q;
  assign stat_drop_o = drop_q;
  assign ctr_o       = ctr_q;
  assign done_o      = done_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_bsg_manycore_pod_reset_sequencer.sv
// Bench for the pod reset sequencer: directed plan steps plus random
// traffic against an edge-indexed reference model.
module tb_bsg_manycore_pod_reset_sequencer;

  localparam int N  = 4;
  localparam int D  = 3;
  localparam int S  = 2;
  localparam int TO = 100;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  tag = '0;
  logic          fin = 1'b0;
  logic          sv = 1'b0;
  logic [31:0]   stag = '0;
  logic          yumi = 1'b0;

  logic [N-1:0]  chan_a, chan_b;
  logic          all_a, all_b;
  logic          sv_o, drop_o, done_o, to_o;
  logic [31:0]   stag_o, sctr_o, ctr_o;
  logic          sv_b, drop_b, done_b, to_b;
  logic [31:0]   stag_b, sctr_b, ctr_b;

  int cmp = 0;
  int errs = 0;

  int e, streak, rel, ctr_m;
  bit done_m, to_m, drop_m;
  ent_t q[$];

  always #5 clk = ~clk;

  bsg_manycore_pod_reset_sequencer #(
    .num_channels_p(N), .reset_depth_p(D),
    .stagger_cycles_p(S), .ctr_width_p(32),
    .timeout_cycles_p(TO), .tag_width_p(32)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .tag_done_i(tag),
    .channel_reset_o(chan_a), .all_out_of_reset_o(all_a),
    .finish_i(fin), .stat_v_i(sv), .stat_tag_i(stag),
    .stat_v_o(sv_o), .stat_tag_o(stag_o),
    .stat_ctr_o(sctr_o), .stat_yumi_i(yumi),
    .stat_drop_o(drop_o), .ctr_o(ctr_o),
    .done_o(done_o), .timeout_o(to_o)
  );

  bsg_manycore_pod_reset_sequencer #(
    .num_channels_p(N), .reset_depth_p(D),
    .stagger_cycles_p(0), .ctr_width_p(32),
    .timeout_cycles_p(0), .tag_width_p(32)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .tag_done_i(tag),
    .channel_reset_o(chan_b), .all_out_of_reset_o(all_b),
    .finish_i(fin), .stat_v_i(1'b0), .stat_tag_i(32'h0),
    .stat_v_o(sv_b), .stat_tag_o(stag_b),
    .stat_ctr_o(sctr_b), .stat_yumi_i(1'b0),
    .stat_drop_o(drop_b), .ctr_o(ctr_b),
    .done_o(done_b), .timeout_o(to_b)
  );

  task automatic chk(string nm, logic [63:0] obs,
                     logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; streak = 0; rel = -1; ctr_m = 0;
    done_m = 0; to_m = 0; drop_m = 0;
    q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_chan", 64'(chan_a), 64'hF);
    chk("rst_all", 64'(all_a), 0);
    chk("rst_ctr", 64'(ctr_o), 0);
    chk("rst_sv", 64'(sv_o), 0);
    chk("rst_stag", 64'(stag_o), 0);
    chk("rst_sctr", 64'(sctr_o), 0);
    chk("rst_drop", 64'(drop_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_to", 64'(to_o), 0);
    chk("rst_chan_b", 64'(chan_b), 64'hF);
  endtask

  // One-cycle reset pulse asserted between edges.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tag = '0; fin = 0; sv = 0; yumi = 0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance one edge, update the model, compare everything.
  task automatic cyc();
    bit run_c;
    logic [N-1:0] ec;
    int rs;
    @(posedge clk);
    e++;
    rs = rel + (N - 1) * S;
    run_c = (rel >= 0) && (e - 1 >= rs) && !to_m;
    if (rel < 0) begin
      if (&tag) streak++;
      else streak = 0;
      if (streak == D) rel = e;
    end else if (run_c) begin
      if (sv) begin
        if (q.size() == 0 || yumi) begin
          if (yumi) void'(q.pop_front());
          q.push_back('{stag, 32'(ctr_m)});
        end else begin
          drop_m = 1;
        end
      end else if (yumi && q.size() > 0) begin
        void'(q.pop_front());
      end
      if (!done_m) begin
        if (fin) done_m = 1;
        else if (ctr_m == TO) to_m = 1;
        else ctr_m++;
      end
    end
    #1;
    rs = rel + (N - 1) * S;
    for (int k = 0; k < N; k++)
      ec[k] = to_m || !(rel >= 0 && e >= rel + k * S);
    chk("chan", 64'(chan_a), 64'(ec));
    chk("all", 64'(all_a),
        64'((rel >= 0) && (e >= rs) && !to_m));
    chk("ctr", 64'(ctr_o), 64'(ctr_m));
    chk("done", 64'(done_o), 64'(done_m));
    chk("timeout", 64'(to_o), 64'(to_m));
    chk("drop", 64'(drop_o), 64'(drop_m));
    chk("stat_v", 64'(sv_o), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("stat_tag", 64'(stag_o), 64'(q[0].t));
      chk("stat_ctr", 64'(sctr_o), 64'(q[0].c));
    end
    chk("chan_b", 64'(chan_b),
        (rel >= 0 && e >= rel) ? 64'h0 : 64'hF);
    chk("all_b", 64'(all_b), 64'(rel >= 0 && e >= rel));
  endtask

  task automatic rand_stat();
    sv   = ($urandom % 3) == 0;
    stag = $urandom;
    yumi = (q.size() > 0) && ($urandom % 2 == 1);
  endtask

  task automatic idle();
    sv = 0; yumi = 0; fin = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] pat [6];
    int budget;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // Release sequence, stat buffer and watchdog.
    repeat (10) cyc();
    tag = 4'hF;
    repeat (3) cyc();
    chk("p1_ch0_e13", 64'(chan_a), 64'hE);
    repeat (5) cyc();
    chk("p1_e18", 64'(chan_a), 64'h8);
    cyc();
    chk("p1_e19_chan", 64'(chan_a), 64'h0);
    chk("p1_e19_all", 64'(all_a), 1);
    chk("p1_e19_ctr", 64'(ctr_o), 0);
    repeat (5) cyc();
    chk("p1_e24_ctr", 64'(ctr_o), 5);
    sv = 1; stag = 32'hABCD;
    cyc();
    idle();
    chk("p3_cap_v", 64'(sv_o), 1);
    chk("p3_cap_tag", 64'(stag_o), 64'hABCD);
    chk("p3_cap_ctr", 64'(sctr_o), 5);
    cyc();
    sv = 1; stag = 32'h1234;
    cyc();
    idle();
    chk("p3_drop", 64'(drop_o), 1);
    chk("p3_keep", 64'(sctr_o), 5);
    cyc();
    sv = 1; yumi = 1; stag = 32'h5555;
    cyc();
    idle();
    chk("p3_repl_ctr", 64'(sctr_o), 9);
    chk("p3_repl_tag", 64'(stag_o), 64'h5555);
    while (e < 119) begin
      rand_stat();
      cyc();
    end
    idle();
    chk("p4_ctr100", 64'(ctr_o), 100);
    cyc();
    chk("p4_to", 64'(to_o), 1);
    chk("p4_chan", 64'(chan_a), 64'hF);
    chk("p4_all", 64'(all_a), 0);
    chk("p4_hold", 64'(ctr_o), 100);
    fin = 1;
    repeat (5) cyc();
    fin = 0;
    chk("p4_fin_ign", 64'(done_o), 0);
    chk("p4_hold2", 64'(ctr_o), 100);

    // Glitched qualification, then finish before timeout.
    pulse_reset();
    repeat (10) cyc();
    pat = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};
    for (int i = 0; i < 6; i++) begin
      tag = pat[i];
      cyc();
      if (i == 4) chk("p2_no_rel", 64'(chan_a), 64'hF);
    end
    chk("p2_rel_e16", 64'(chan_a), 64'hE);
    tag = 4'h0;
    while (e < 62) begin
      rand_stat();
      cyc();
    end
    idle();
    chk("p5_ctr40", 64'(ctr_o), 40);
    fin = 1;
    cyc();
    fin = 0;
    chk("p5_done", 64'(done_o), 1);
    repeat (210) begin
      rand_stat();
      cyc();
    end
    idle();
    chk("p5_frozen", 64'(ctr_o), 40);
    chk("p5_no_to", 64'(to_o), 0);
    chk("p5_done2", 64'(done_o), 1);

    // Reset mid-run, then random requalification.
    pulse_reset();
    tag = 4'hF;
    while (e < 20) cyc();
    sv = 1; stag = 32'hBEEF;
    cyc();
    cyc();
    idle();
    while (e < 39) cyc();
    chk("p6_ctr30", 64'(ctr_o), 30);
    pulse_reset();
    budget = 0;
    while (rel < 0 && budget < 300) begin
      tag = ($urandom % 3 == 0) ? 4'($urandom) : 4'hF;
      cyc();
      budget++;
    end
    chk("p6_requal", 64'(rel >= 0), 1);
    tag = 4'($urandom);
    repeat (150) begin
      rand_stat();
      fin = ($urandom % 60) == 0;
      cyc();
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, errs);
    $finish;
  end

endmodule
